// File: rtl/button_conditioner.sv
// Plus/Minus push-button front end: synchronise, debounce and turn presses
// into single-cycle step pulses with auto-repeat while a button is held.
// Channel 0 is Plus, channel 1 is Minus. Each channel has the same pipeline:
// a synchroniser, a debouncer and a small FSM. The FSMs look at each other's
// debounced level so that holding both buttons never produces a step.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_RATE     = 10000000,
  parameter int CNT_W           = 27
) (
  input  logic sysclk,
  input  logic rst_n,
  input  logic Bt_Plus_Raw,
  input  logic Bt_Minus_Raw,
  input  logic Enable,
  output logic Plus_Pulse,
  output logic Minus_Pulse,
  output logic Plus_Level,
  output logic Minus_Level
);

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    REPEAT,
    WAIT_RELEASE,
    LOCK
  } state_t;

  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic [1:0] raw;
  logic [1:0] level;
  logic [1:0] pulse;

  assign raw = {Bt_Minus_Raw, Bt_Plus_Raw};

  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    localparam int OTHER = 1 - gi;

    logic             s1_q;
    logic             s2_q;
    logic             level_q;
    logic             pulse_q;
    logic [CNT_W-1:0] dcnt_q;
    logic [CNT_W-1:0] hcnt_q;
    state_t           state_q;
    logic             both_held;

    // Both debounced levels high means a conflicting press: neither channel steps.
    assign both_held = level_q & level[OTHER];

    // Two-flop synchroniser for the asynchronous button input.
    always_ff @(posedge sysclk) begin
      if (!rst_n) begin
        s1_q <= 1'b0;
        s2_q <= 1'b0;
      end else begin
        s1_q <= raw[gi];
        s2_q <= s1_q;
      end
    end

    // Debounce: the level only follows s2 after it has disagreed for
    // DEBOUNCE_CYCLES consecutive samples; any agreement restarts the count.
    always_ff @(posedge sysclk) begin
      if (!rst_n) begin
        dcnt_q  <= '0;
        level_q <= 1'b0;
      end else if (s2_q == level_q) begin
        dcnt_q <= '0;
      end else if (dcnt_q == DB_LAST) begin
        dcnt_q  <= '0;
        level_q <= ~level_q;
      end else begin
        dcnt_q <= dcnt_q + CNT_ONE;
      end
    end

    // Press / auto-repeat FSM with a registered one-cycle pulse output.
    // A pulse is only ever issued while the other level is low, which keeps
    // the Plus and Minus pulses mutually exclusive.
    always_ff @(posedge sysclk) begin
      if (!rst_n) begin
        state_q <= IDLE;
        hcnt_q  <= '0;
        pulse_q <= 1'b0;
      end else begin
        pulse_q <= 1'b0;
        if (both_held) begin
          state_q <= LOCK;
          hcnt_q  <= '0;
        end else begin
          case (state_q)
            IDLE: begin
              hcnt_q <= '0;
              if (level_q) begin
                if (Enable) begin
                  pulse_q <= 1'b1;
                  state_q <= HOLD;
                end else begin
                  state_q <= WAIT_RELEASE;
                end
              end
            end
            HOLD, REPEAT: begin
              if (!level_q) begin
                state_q <= IDLE;
                hcnt_q  <= '0;
              end else if (!Enable) begin
                state_q <= WAIT_RELEASE;
                hcnt_q  <= '0;
              end else if (hcnt_q == ((state_q == HOLD) ? DELAY_LAST : RATE_LAST)) begin
                pulse_q <= 1'b1;
                state_q <= REPEAT;
                hcnt_q  <= '0;
              end else if (hcnt_q != CNT_MAX) begin
                hcnt_q <= hcnt_q + CNT_ONE;
              end
            end
            WAIT_RELEASE: begin
              hcnt_q <= '0;
              if (!level_q) state_q <= IDLE;
            end
            LOCK: begin
              // Other level is low here, so a still-held channel must wait.
              hcnt_q  <= '0;
              state_q <= level_q ? WAIT_RELEASE : IDLE;
            end
            default: begin
              state_q <= IDLE;
              hcnt_q  <= '0;
            end
          endcase
        end
      end
    end

    assign level[gi] = level_q;
    assign pulse[gi] = pulse_q;
  end

  assign Plus_Pulse  = pulse[0];
  assign Minus_Pulse = pulse[1];
  assign Plus_Level  = level[0];
  assign Minus_Level = level[1];

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with small timing parameters.
// Edge k of a scenario is the k-th rising edge after the scenario starts;
// stimulus for edge k is applied 1 ns after edge k-1 and outputs are
// sampled 1 ns after edge k. Expected pulse edges go into queues up front
// and are popped as the DUT produces pulses.
module tb_button_conditioner;

  logic sysclk = 1'b0;
  logic rst_n;
  logic Bt_Plus_Raw;
  logic Bt_Minus_Raw;
  logic Enable;
  logic Plus_Pulse;
  logic Minus_Pulse;
  logic Plus_Level;
  logic Minus_Level;

  int n_checks = 0;
  int n_fail   = 0;
  int px[$];
  int mx[$];

  button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (10),
    .REPEAT_RATE    (3),
    .CNT_W          (8)
  ) dut (
    .sysclk      (sysclk),
    .rst_n       (rst_n),
    .Bt_Plus_Raw (Bt_Plus_Raw),
    .Bt_Minus_Raw(Bt_Minus_Raw),
    .Enable      (Enable),
    .Plus_Pulse  (Plus_Pulse),
    .Minus_Pulse (Minus_Pulse),
    .Plus_Level  (Plus_Level),
    .Minus_Level (Minus_Level)
  );

  always #5 sysclk = ~sysclk;

  task automatic step();
    @(posedge sysclk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    Bt_Plus_Raw = 1'b0;
    Bt_Minus_Raw = 1'b0;
    Enable = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    px.delete();
    mx.delete();
  endtask

  // Reset with both buttons held, then release reset: simultaneous rise -> LOCK.
  task automatic test_reset();
    rst_n = 1'b0;
    Bt_Plus_Raw = 1'b1;
    Bt_Minus_Raw = 1'b1;
    Enable = 1'b1;
    repeat (3) step();
    n_checks += 4;
    if (Plus_Pulse !== 1'b0)  begin n_fail++; $display("FAIL reset_plus_pulse got %b expected 0", Plus_Pulse); end
    if (Minus_Pulse !== 1'b0) begin n_fail++; $display("FAIL reset_minus_pulse got %b expected 0", Minus_Pulse); end
    if (Plus_Level !== 1'b0)  begin n_fail++; $display("FAIL reset_plus_level got %b expected 0", Plus_Level); end
    if (Minus_Level !== 1'b0) begin n_fail++; $display("FAIL reset_minus_level got %b expected 0", Minus_Level); end
    rst_n = 1'b1;
    for (int k = 0; k <= 14; k++) begin
      logic el;
      step();
      el = (k >= 5);
      n_checks += 4;
      if (Plus_Pulse !== 1'b0)  begin n_fail++; $display("FAIL lock_plus_pulse edge %0d got %b expected 0", k, Plus_Pulse); end
      if (Minus_Pulse !== 1'b0) begin n_fail++; $display("FAIL lock_minus_pulse edge %0d got %b expected 0", k, Minus_Pulse); end
      if (Plus_Level !== el)    begin n_fail++; $display("FAIL lock_plus_level edge %0d got %b expected %b", k, Plus_Level, el); end
      if (Minus_Level !== el)   begin n_fail++; $display("FAIL lock_minus_level edge %0d got %b expected %b", k, Minus_Level, el); end
    end
    Bt_Plus_Raw = 1'b0;
    Bt_Minus_Raw = 1'b0;
    for (int k = 0; k <= 8; k++) begin
      step();
      n_checks += 2;
      if (Plus_Pulse !== 1'b0)  begin n_fail++; $display("FAIL unlock_plus_pulse edge %0d got %b expected 0", k, Plus_Pulse); end
      if (Minus_Pulse !== 1'b0) begin n_fail++; $display("FAIL unlock_minus_pulse edge %0d got %b expected 0", k, Minus_Pulse); end
    end
    n_checks += 2;
    if (Plus_Level !== 1'b0)  begin n_fail++; $display("FAIL unlock_plus_level got %b expected 0", Plus_Level); end
    if (Minus_Level !== 1'b0) begin n_fail++; $display("FAIL unlock_minus_level got %b expected 0", Minus_Level); end
    $display("reset: lock on simultaneous press checked, checks=%0d failures=%0d", n_checks, n_fail);
  endtask

  // Plus high for edges 0..7: level high after edge 5, pulse after edge 6, level low after edge 13.
  task automatic test_clean_press();
    apply_reset();
    px.push_back(6);
    for (int k = 0; k <= 20; k++) begin
      logic ep, el;
      Bt_Plus_Raw = (k < 8);
      step();
      ep = (px.size() > 0 && px[0] == k);
      if (ep) void'(px.pop_front());
      el = (k >= 5 && k < 13);
      n_checks += 3;
      if (Plus_Pulse !== ep)    begin n_fail++; $display("FAIL clean_plus_pulse edge %0d got %b expected %b", k, Plus_Pulse, ep); end
      if (Minus_Pulse !== 1'b0) begin n_fail++; $display("FAIL clean_minus_pulse edge %0d got %b expected 0", k, Minus_Pulse); end
      if (Plus_Level !== el)    begin n_fail++; $display("FAIL clean_plus_level edge %0d got %b expected %b", k, Plus_Level, el); end
    end
    n_checks++;
    if (px.size() != 0) begin n_fail++; $display("FAIL clean_missing_pulses got %0d left expected 0", px.size()); end
    $display("clean_press: single pulse and level timing checked, checks=%0d failures=%0d", n_checks, n_fail);
  endtask

  // Minus bounces 1,0,1,1,0 then holds from edge 5: level after edge 10, one pulse after edge 11.
  task automatic test_bounce();
    apply_reset();
    mx.push_back(11);
    for (int k = 0; k <= 25; k++) begin
      logic em;
      Bt_Minus_Raw = (k == 0) || (k == 2) || (k == 3) || (k >= 5 && k <= 12);
      step();
      em = (mx.size() > 0 && mx[0] == k);
      if (em) void'(mx.pop_front());
      n_checks += 3;
      if (Minus_Pulse !== em)   begin n_fail++; $display("FAIL bounce_minus_pulse edge %0d got %b expected %b", k, Minus_Pulse, em); end
      if (Plus_Pulse !== 1'b0)  begin n_fail++; $display("FAIL bounce_plus_pulse edge %0d got %b expected 0", k, Plus_Pulse); end
      if (Minus_Level !== (k >= 10 && k < 18)) begin
        n_fail++; $display("FAIL bounce_minus_level edge %0d got %b", k, Minus_Level);
      end
    end
    n_checks++;
    if (mx.size() != 0) begin n_fail++; $display("FAIL bounce_missing_pulses got %0d left expected 0", mx.size()); end
    $display("bounce: glitches rejected, one pulse checked, checks=%0d failures=%0d", n_checks, n_fail);
  endtask

  // Plus high for edges 0..23: level high edges 5..28, pulses at 6, 16, 19, 22, 25, 28.
  task automatic test_auto_repeat();
    apply_reset();
    px.push_back(6);  px.push_back(16); px.push_back(19);
    px.push_back(22); px.push_back(25); px.push_back(28);
    for (int k = 0; k <= 40; k++) begin
      logic ep;
      Bt_Plus_Raw = (k < 24);
      step();
      ep = (px.size() > 0 && px[0] == k);
      if (ep) void'(px.pop_front());
      n_checks += 2;
      if (Plus_Pulse !== ep)    begin n_fail++; $display("FAIL repeat_plus_pulse edge %0d got %b expected %b", k, Plus_Pulse, ep); end
      if (Minus_Pulse !== 1'b0) begin n_fail++; $display("FAIL repeat_minus_pulse edge %0d got %b expected 0", k, Minus_Pulse); end
    end
    n_checks++;
    if (px.size() != 0) begin n_fail++; $display("FAIL repeat_missing_pulses got %0d left expected 0", px.size()); end
    $display("auto_repeat: delay and rate checked, checks=%0d failures=%0d", n_checks, n_fail);
  endtask

  // Plus held, Minus pressed during HOLD -> LOCK; release Minus -> Plus waits; re-press Plus.
  task automatic test_conflict();
    apply_reset();
    px.push_back(6);
    px.push_back(41);
    for (int k = 0; k <= 55; k++) begin
      logic ep, el;
      Bt_Plus_Raw  = (k < 25) || (k >= 35 && k < 43);
      Bt_Minus_Raw = (k >= 3 && k < 15);
      step();
      ep = (px.size() > 0 && px[0] == k);
      if (ep) void'(px.pop_front());
      el = (k >= 5 && k < 30) || (k >= 40 && k < 48);
      n_checks += 4;
      if (Plus_Pulse !== ep)    begin n_fail++; $display("FAIL conflict_plus_pulse edge %0d got %b expected %b", k, Plus_Pulse, ep); end
      if (Minus_Pulse !== 1'b0) begin n_fail++; $display("FAIL conflict_minus_pulse edge %0d got %b expected 0", k, Minus_Pulse); end
      if (Plus_Level !== el)    begin n_fail++; $display("FAIL conflict_plus_level edge %0d got %b expected %b", k, Plus_Level, el); end
      if (Plus_Pulse && Minus_Pulse) begin n_fail++; $display("FAIL conflict_exclusive edge %0d got both pulses expected at most one", k); end
    end
    n_checks++;
    if (px.size() != 0) begin n_fail++; $display("FAIL conflict_missing_pulses got %0d left expected 0", px.size()); end
    $display("conflict: lock and no-resume checked, checks=%0d failures=%0d", n_checks, n_fail);
  endtask

  // Enable dropped during REPEAT, then a Minus press while disabled; no resume on re-enable.
  task automatic test_enable();
    apply_reset();
    px.push_back(6);  px.push_back(16); px.push_back(19);
    px.push_back(56);
    for (int k = 0; k <= 88; k++) begin
      logic ep, em;
      Bt_Plus_Raw  = (k <= 40) || (k >= 50 && k <= 57);
      Bt_Minus_Raw = (k >= 60 && k <= 75);
      Enable       = !((k >= 21 && k <= 25) || (k >= 60 && k <= 70));
      step();
      ep = (px.size() > 0 && px[0] == k);
      if (ep) void'(px.pop_front());
      em = (mx.size() > 0 && mx[0] == k);
      if (em) void'(mx.pop_front());
      n_checks += 3;
      if (Plus_Pulse !== ep)  begin n_fail++; $display("FAIL enable_plus_pulse edge %0d got %b expected %b", k, Plus_Pulse, ep); end
      if (Minus_Pulse !== em) begin n_fail++; $display("FAIL enable_minus_pulse edge %0d got %b expected %b", k, Minus_Pulse, em); end
      if (Minus_Level !== (k >= 65 && k < 81)) begin
        n_fail++; $display("FAIL enable_minus_level edge %0d got %b", k, Minus_Level);
      end
    end
    n_checks++;
    if (px.size() != 0) begin n_fail++; $display("FAIL enable_missing_pulses got %0d left expected 0", px.size()); end
    $display("enable: suppression and no-resume checked, checks=%0d failures=%0d", n_checks, n_fail);
  endtask

  // Reset asserted while Plus repeats and Minus is mid-debounce clears everything.
  task automatic test_reset_mid();
    apply_reset();
    px.push_back(6);
    px.push_back(16);
    for (int k = 0; k <= 18; k++) begin
      logic ep;
      Bt_Plus_Raw  = 1'b1;
      Bt_Minus_Raw = (k >= 16);
      step();
      ep = (px.size() > 0 && px[0] == k);
      if (ep) void'(px.pop_front());
      n_checks++;
      if (Plus_Pulse !== ep) begin n_fail++; $display("FAIL midreset_plus_pulse edge %0d got %b expected %b", k, Plus_Pulse, ep); end
    end
    rst_n = 1'b0;
    step();
    n_checks += 3;
    if (Plus_Pulse !== 1'b0)  begin n_fail++; $display("FAIL midreset_pulse got %b expected 0", Plus_Pulse); end
    if (Plus_Level !== 1'b0)  begin n_fail++; $display("FAIL midreset_plus_level got %b expected 0", Plus_Level); end
    if (Minus_Level !== 1'b0) begin n_fail++; $display("FAIL midreset_minus_level got %b expected 0", Minus_Level); end
    Bt_Plus_Raw = 1'b0;
    Bt_Minus_Raw = 1'b0;
    rst_n = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      step();
      n_checks += 2;
      if (Plus_Level !== 1'b0 || Plus_Pulse !== 1'b0) begin
        n_fail++; $display("FAIL midreset_after_plus edge %0d got level %b pulse %b expected 0 0", k, Plus_Level, Plus_Pulse);
      end
      if (Minus_Level !== 1'b0 || Minus_Pulse !== 1'b0) begin
        n_fail++; $display("FAIL midreset_after_minus edge %0d got level %b pulse %b expected 0 0", k, Minus_Level, Minus_Pulse);
      end
    end
    $display("reset_mid: reset priority checked, checks=%0d failures=%0d", n_checks, n_fail);
  endtask

  initial begin
    rst_n = 1'b0;
    Bt_Plus_Raw = 1'b0;
    Bt_Minus_Raw = 1'b0;
    Enable = 1'b1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_auto_repeat();
    test_conflict();
    test_enable();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
